// File: rtl/rv_iopmp_tl_arbiter.sv
// IOPMP transaction-logic front-end: round-robin arbitration of read/write requests,
// single-request serialisation into the transaction logic and a decision watchdog.

package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        ACCESS_NONE      = 2'd0,
        ACCESS_READ      = 2'd1,
        ACCESS_WRITE     = 2'd2,
        ACCESS_EXECUTION = 2'd3
    } access_t;

endpackage

module rv_iopmp_tl_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned SID_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned NB            = $clog2(DATA_WIDTH / 8) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    rd_req_valid_i,
    output logic                    rd_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    input  logic [NB-1:0]           rd_num_bytes_i,
    input  logic [SID_WIDTH-1:0]    rd_sid_i,
    input  logic                    rd_exec_i,

    input  logic                    wr_req_valid_i,
    output logic                    wr_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [NB-1:0]           wr_num_bytes_i,
    input  logic [SID_WIDTH-1:0]    wr_sid_i,

    output logic                    rd_rsp_valid_o,
    output logic                    rd_rsp_allow_o,
    input  logic                    rd_rsp_ready_i,

    output logic                    wr_rsp_valid_o,
    output logic                    wr_rsp_allow_o,
    input  logic                    wr_rsp_ready_i,

    output logic                    tl_transaction_en_o,
    output logic [ADDR_WIDTH-1:0]   tl_addr_o,
    output logic [NB-1:0]           tl_num_bytes_o,
    output logic [SID_WIDTH-1:0]    tl_sid_o,
    output rv_iopmp_pkg::access_t   tl_access_type_o,
    input  logic                    tl_ready_i,
    input  logic                    tl_valid_i,
    input  logic                    tl_allow_i,

    output logic                    timeout_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [1:0]              state_q, state_d;
    logic                    rr_ptr_q, rr_ptr_d;
    logic                    owner_q, owner_d;
    logic                    allow_q, allow_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NB-1:0]           num_bytes_q, num_bytes_d;
    logic [SID_WIDTH-1:0]    sid_q, sid_d;
    rv_iopmp_pkg::access_t   type_q, type_d;

    logic                    is_idle;
    logic                    grant_rd;
    logic                    grant_wr;
    logic                    owner_rsp_ready;
    logic                    timeout;

    // rr_ptr only breaks ties; a lone valid channel is always granted.
    assign is_idle  = (state_q == ST_IDLE);
    assign grant_rd = rd_req_valid_i && (!wr_req_valid_i || !rr_ptr_q);
    assign grant_wr = wr_req_valid_i && (!rd_req_valid_i || rr_ptr_q);

    assign rd_req_ready_o = is_idle && grant_rd;
    assign wr_req_ready_o = is_idle && grant_wr;

    assign owner_rsp_ready = owner_q ? wr_rsp_ready_i : rd_rsp_ready_i;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        allow_d     = allow_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        num_bytes_d = num_bytes_q;
        sid_d       = sid_q;
        type_d      = type_q;
        timeout     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rd_req_ready_o) begin
                    addr_d      = rd_addr_i;
                    num_bytes_d = rd_num_bytes_i;
                    sid_d       = rd_sid_i;
                    owner_d     = 1'b0;
                    type_d      = rd_exec_i ? rv_iopmp_pkg::ACCESS_EXECUTION
                                            : rv_iopmp_pkg::ACCESS_READ;
                    state_d     = ST_ISSUE;
                end else if (wr_req_ready_o) begin
                    addr_d      = wr_addr_i;
                    num_bytes_d = wr_num_bytes_i;
                    sid_d       = wr_sid_i;
                    owner_d     = 1'b1;
                    type_d      = rv_iopmp_pkg::ACCESS_WRITE;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tl_ready_i) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // A decision arriving on the expiry cycle takes precedence over the watchdog.
                if (tl_valid_i) begin
                    allow_d = tl_allow_i;
                    state_d = ST_RESP;
                end else if (WD_EN && (cnt_q == CNT_LAST)) begin
                    allow_d = 1'b0;
                    timeout = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (owner_rsp_ready) begin
                    rr_ptr_d = ~owner_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 1'b0;
            owner_q     <= 1'b0;
            allow_q     <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            num_bytes_q <= '0;
            sid_q       <= '0;
            type_q      <= rv_iopmp_pkg::ACCESS_NONE;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            allow_q     <= allow_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            num_bytes_q <= num_bytes_d;
            sid_q       <= sid_d;
            type_q      <= type_d;
        end
    end

    assign tl_transaction_en_o = (state_q == ST_ISSUE);
    assign tl_addr_o           = addr_q;
    assign tl_num_bytes_o      = num_bytes_q;
    assign tl_sid_o            = sid_q;
    assign tl_access_type_o    = type_q;

    assign rd_rsp_valid_o = (state_q == ST_RESP) && !owner_q;
    assign wr_rsp_valid_o = (state_q == ST_RESP) && owner_q;
    assign rd_rsp_allow_o = rd_rsp_valid_o && allow_q;
    assign wr_rsp_allow_o = wr_rsp_valid_o && allow_q;

    assign timeout_o = timeout;

endmodule

// File: tb/tb_rv_iopmp_tl_arbiter.sv
// Scoreboard bench for rv_iopmp_tl_arbiter: expected issue fields and responses are queued
// by the stimulus and checked by an independent monitor.

module tb_rv_iopmp_tl_arbiter;
    import rv_iopmp_pkg::*;

    localparam int TO = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         rd_req_valid_i, rd_req_ready_o;
    logic [63:0]  rd_addr_i;
    logic [3:0]   rd_num_bytes_i;
    logic [7:0]   rd_sid_i;
    logic         rd_exec_i;
    logic         wr_req_valid_i, wr_req_ready_o;
    logic [63:0]  wr_addr_i;
    logic [3:0]   wr_num_bytes_i;
    logic [7:0]   wr_sid_i;
    logic         rd_rsp_valid_o, rd_rsp_allow_o, rd_rsp_ready_i;
    logic         wr_rsp_valid_o, wr_rsp_allow_o, wr_rsp_ready_i;
    logic         tl_transaction_en_o;
    logic [63:0]  tl_addr_o;
    logic [3:0]   tl_num_bytes_o;
    logic [7:0]   tl_sid_o;
    access_t      tl_access_type_o;
    logic         tl_ready_i, tl_valid_i, tl_allow_i;
    logic         timeout_o;

    rv_iopmp_tl_arbiter #(
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (64),
        .SID_WIDTH      (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .rd_req_valid_i      (rd_req_valid_i),
        .rd_req_ready_o      (rd_req_ready_o),
        .rd_addr_i           (rd_addr_i),
        .rd_num_bytes_i      (rd_num_bytes_i),
        .rd_sid_i            (rd_sid_i),
        .rd_exec_i           (rd_exec_i),
        .wr_req_valid_i      (wr_req_valid_i),
        .wr_req_ready_o      (wr_req_ready_o),
        .wr_addr_i           (wr_addr_i),
        .wr_num_bytes_i      (wr_num_bytes_i),
        .wr_sid_i            (wr_sid_i),
        .rd_rsp_valid_o      (rd_rsp_valid_o),
        .rd_rsp_allow_o      (rd_rsp_allow_o),
        .rd_rsp_ready_i      (rd_rsp_ready_i),
        .wr_rsp_valid_o      (wr_rsp_valid_o),
        .wr_rsp_allow_o      (wr_rsp_allow_o),
        .wr_rsp_ready_i      (wr_rsp_ready_i),
        .tl_transaction_en_o (tl_transaction_en_o),
        .tl_addr_o           (tl_addr_o),
        .tl_num_bytes_o      (tl_num_bytes_o),
        .tl_sid_o            (tl_sid_o),
        .tl_access_type_o    (tl_access_type_o),
        .tl_ready_i          (tl_ready_i),
        .tl_valid_i          (tl_valid_i),
        .tl_allow_i          (tl_allow_i),
        .timeout_o           (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  nb;
        logic [7:0]  sid;
        access_t     at;
    } tl_exp_t;

    typedef struct packed {
        logic ch;
        logic allow;
    } rsp_exp_t;

    tl_exp_t  tl_q[$];
    rsp_exp_t rsp_q[$];
    rsp_exp_t mon_e;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name,
              {tl_transaction_en_o, rd_req_ready_o, wr_req_ready_o, rd_rsp_valid_o,
               wr_rsp_valid_o, rd_rsp_allow_o, wr_rsp_allow_o, timeout_o,
               tl_addr_o, tl_num_bytes_o, tl_sid_o, tl_access_type_o},
              {8'h00, 64'h0, 4'h0, 8'h00, ACCESS_NONE});
    endtask

    // Monitor: checks issue fields while en is high, pops on each accepted handshake.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (tl_transaction_en_o) begin
                if (tl_q.size() == 0) begin
                    fail("tl_unexpected_issue");
                end else begin
                    check("tl_fields", {tl_addr_o, tl_num_bytes_o, tl_sid_o, tl_access_type_o},
                          {tl_q[0].addr, tl_q[0].nb, tl_q[0].sid, tl_q[0].at});
                    if (tl_ready_i) void'(tl_q.pop_front());
                end
            end
            if (rd_rsp_valid_o && wr_rsp_valid_o) fail("rsp_both_valid");
            if (rd_rsp_valid_o && rd_rsp_ready_i) begin
                if (rsp_q.size() == 0) fail("rd_rsp_unexpected");
                else begin
                    mon_e = rsp_q.pop_front();
                    check("rsp_channel", 1'b0, mon_e.ch);
                    check("rd_rsp_allow", rd_rsp_allow_o, mon_e.allow);
                end
            end
            if (wr_rsp_valid_o && wr_rsp_ready_i) begin
                if (rsp_q.size() == 0) fail("wr_rsp_unexpected");
                else begin
                    mon_e = rsp_q.pop_front();
                    check("rsp_channel", 1'b1, mon_e.ch);
                    check("wr_rsp_allow", wr_rsp_allow_o, mon_e.allow);
                end
            end
        end
    end

    // One full request: present, issue with back-pressure, decide (or expire), respond.
    task automatic do_req(input bit both, input bit ch, input bit exp_ch,
                          input logic [63:0] addr, input logic [3:0] nb, input logic [7:0] sid,
                          input bit exec, input int rdy_dly, input int dec_cyc,
                          input bit allow, input int rsp_dly, input bit exp_allow,
                          input bit exp_to, input bit rst_wait);
        tl_exp_t te;
        rsp_exp_t re;
        bit hs;
        bit got;
        int c;
        int to_cnt;
        rd_addr_i      = addr;
        rd_num_bytes_i = nb;
        rd_sid_i       = sid;
        rd_exec_i      = exec;
        wr_addr_i      = addr ^ 64'h1000;
        wr_num_bytes_i = nb ^ 4'h3;
        wr_sid_i       = sid ^ 8'h80;
        rd_req_valid_i = both || !ch;
        wr_req_valid_i = both || ch;
        te.addr = exp_ch ? (addr ^ 64'h1000) : addr;
        te.nb   = exp_ch ? (nb ^ 4'h3) : nb;
        te.sid  = exp_ch ? (sid ^ 8'h80) : sid;
        te.at   = exp_ch ? ACCESS_WRITE : (exec ? ACCESS_EXECUTION : ACCESS_READ);
        re.ch    = exp_ch;
        re.allow = exp_allow;
        tl_q.push_back(te);
        rsp_q.push_back(re);

        hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk_i);
            if (rd_req_ready_o || wr_req_ready_o) begin
                check("grant", {rd_req_ready_o, wr_req_ready_o}, exp_ch ? 2'b01 : 2'b10);
                hs = 1'b1;
            end
            @(posedge clk_i);
            #1;
        end
        rd_req_valid_i = 1'b0;
        wr_req_valid_i = 1'b0;
        if (!hs) begin
            fail("req_handshake_timeout");
            return;
        end

        tl_ready_i = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk_i);
            check("issue_en_held", tl_transaction_en_o, 1'b1);
            @(posedge clk_i);
            #1;
        end
        tl_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        tl_ready_i = 1'b0;

        got    = 1'b0;
        to_cnt = 0;
        for (c = 1; c <= 12; c++) begin
            tl_valid_i = (c == dec_cyc);
            tl_allow_i = allow;
            @(negedge clk_i);
            to_cnt += int'(timeout_o);
            if (rst_wait && c == 2) begin
                rst_ni = 1'b0;
                #1;
                check_reset_outputs("reset_in_wait");
                tl_q.delete();
                rsp_q.delete();
                @(posedge clk_i);
                #1;
                rst_ni     = 1'b1;
                tl_valid_i = 1'b1;
                tl_allow_i = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk_i);
                    check("late_valid_ignored",
                          {rd_rsp_valid_o, wr_rsp_valid_o, tl_transaction_en_o, timeout_o}, 4'h0);
                    @(posedge clk_i);
                    #1;
                    tl_valid_i = 1'b0;
                end
                return;
            end
            @(posedge clk_i);
            #1;
            tl_valid_i = 1'b0;
            if (rd_rsp_valid_o || wr_rsp_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail("decision_wait_timeout");
            return;
        end
        check("wait_cycles", c, (dec_cyc != 0) ? dec_cyc : TO);
        check("timeout_pulses", to_cnt, exp_to);

        for (int i = 0; i < rsp_dly; i++) begin
            rd_req_valid_i = 1'b1;
            wr_req_valid_i = 1'b1;
            @(negedge clk_i);
            check("rsp_hold",
                  {exp_ch ? wr_rsp_valid_o : rd_rsp_valid_o,
                   exp_ch ? rd_rsp_valid_o : wr_rsp_valid_o,
                   exp_ch ? wr_rsp_allow_o : rd_rsp_allow_o,
                   rd_req_ready_o, wr_req_ready_o},
                  {1'b1, 1'b0, exp_allow, 1'b0, 1'b0});
            @(posedge clk_i);
            #1;
        end
        rd_req_valid_i = 1'b0;
        wr_req_valid_i = 1'b0;
        rd_rsp_ready_i = !exp_ch;
        wr_rsp_ready_i = exp_ch;
        @(negedge clk_i);
        check("rsp_other_idle", exp_ch ? rd_rsp_valid_o : wr_rsp_valid_o, 1'b0);
        @(posedge clk_i);
        #1;
        rd_rsp_ready_i = 1'b0;
        wr_rsp_ready_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        rd_req_valid_i = 1'b0; wr_req_valid_i = 1'b0;
        rd_addr_i = '0; rd_num_bytes_i = '0; rd_sid_i = '0; rd_exec_i = 1'b0;
        wr_addr_i = '0; wr_num_bytes_i = '0; wr_sid_i = '0;
        rd_rsp_ready_i = 1'b0; wr_rsp_ready_i = 1'b0;
        tl_ready_i = 1'b0; tl_valid_i = 1'b0; tl_allow_i = 1'b0;
        #1;
        check_reset_outputs("reset_values");
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // both   ch  exp  addr                  nb    sid    ex rdy dec al rsp xal to rst
        do_req(1, 0, 0, 64'h0000_0000_1000_0000, 4'd4, 8'h11, 0, 0, 2, 1, 0, 1, 0, 0);
        do_req(1, 0, 1, 64'h0000_0000_2000_0040, 4'd8, 8'h22, 0, 0, 1, 1, 0, 1, 0, 0);
        do_req(1, 0, 0, 64'h0000_0000_3000_0080, 4'd2, 8'h33, 0, 1, 2, 0, 0, 0, 0, 0);
        do_req(1, 0, 1, 64'h0000_0000_4000_00c0, 4'd1, 8'h44, 0, 0, 3, 1, 1, 1, 0, 0);
        do_req(0, 0, 0, 64'h0000_0000_8000_0000, 4'd8, 8'h03, 0, 0, 3, 1, 0, 1, 0, 0);
        do_req(0, 0, 0, 64'h0000_0001_0000_0100, 4'd4, 8'h05, 1, 0, 2, 0, 0, 0, 0, 0);
        do_req(0, 1, 1, 64'hdead_beef_0000_0008, 4'd8, 8'h7e, 0, 5, 1, 1, 4, 1, 0, 0);
        do_req(0, 1, 1, 64'h0000_0000_0000_0010, 4'd8, 8'h09, 0, 0, 0, 1, 0, 0, 1, 0);
        do_req(0, 0, 0, 64'h0000_0000_0000_0020, 4'd8, 8'h0a, 0, 0, 4, 1, 0, 1, 0, 0);
        do_req(0, 0, 0, 64'h0000_0000_5000_0000, 4'd8, 8'h0b, 0, 0, 0, 1, 0, 0, 0, 1);
        do_req(0, 1, 1, 64'h0000_0000_6000_0000, 4'd4, 8'h0c, 0, 0, 2, 1, 0, 1, 0, 0);
        do_req(1, 0, 0, 64'h0000_0000_7000_0000, 4'd2, 8'h0d, 0, 0, 1, 0, 0, 0, 0, 0);

        repeat (2) @(posedge clk_i);
        check("scoreboard_drained", tl_q.size() + rsp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_iopmp_tl_arbiter.md
# rv_iopmp_tl_arbiter

Request front-end for the IOPMP transaction logic. It arbitrates between the read and write request channels of the bus-facing port and serialises one request at a time into the transaction logic's en/ready/valid interface. It returns the allow/deny decision to the originating channel through a valid/ready response handshake. It also enforces a decision watchdog, so a stalled check resolves as a deny.

## Interface
Parameters:
- ADDR_WIDTH, 64, request address width
- DATA_WIDTH, 64, bus data width; num_bytes width is $clog2(DATA_WIDTH/8)+1
- SID_WIDTH, 8, source ID width
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before forced deny; 0 disables the watchdog

Ports (NB = $clog2(DATA_WIDTH/8)+1). One clock; reset is asynchronous and active-low:
- clk_i  in  1  rising-edge clock
- rst_ni  in  1  asynchronous reset, active low
- rd_req_valid_i / rd_req_ready_o  in/out  1  read request handshake
- rd_addr_i  in  ADDR_WIDTH; rd_num_bytes_i  in  NB; rd_sid_i  in  SID_WIDTH; rd_exec_i  in  1  (instruction fetch)
- wr_req_valid_i / wr_req_ready_o  in/out  1  write request handshake
- wr_addr_i  in  ADDR_WIDTH; wr_num_bytes_i  in  NB; wr_sid_i  in  SID_WIDTH
- rd_rsp_valid_o  out  1; rd_rsp_allow_o  out  1; rd_rsp_ready_i  in  1  read decision return
- wr_rsp_valid_o  out  1; wr_rsp_allow_o  out  1; wr_rsp_ready_i  in  1  write decision return
- tl_transaction_en_o  out  1  request strobe to transaction logic
- tl_addr_o  out  ADDR_WIDTH; tl_num_bytes_o  out  NB; tl_sid_o  out  SID_WIDTH; tl_access_type_o  out  rv_iopmp_pkg::access_t
- tl_ready_i  in  1  transaction logic idle
- tl_valid_i  in  1  one-cycle decision strobe
- tl_allow_i  in  1  decision, qualified by tl_valid_i
- timeout_o  out  1  one-cycle pulse on watchdog expiry

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - rr_ptr (0 = read, 1 = write; resets to 0) selects the preferred channel when both are valid. If only one channel is valid, that channel is granted.
  - req_ready_o is high only for the granted channel, combinationally, and only in IDLE.
  - On handshake: register addr/num_bytes/sid/owner; access type is ACCESS_EXECUTION if rd_exec_i, else ACCESS_READ for the read channel, ACCESS_WRITE for the write channel. Then go to ISSUE.
- ISSUE:
  - tl_transaction_en_o = 1. The tl_* fields are driven from the registers.
  - When tl_ready_i = 1 at the clock edge, go to WAIT and clear the watchdog counter. Otherwise stay in ISSUE.
- WAIT:
  - tl_transaction_en_o = 0. The counter increments each cycle.
  - On tl_valid_i: latch tl_allow_i, go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and the counter == TIMEOUT_CYCLES-1: latch allow = 0, pulse timeout_o, go to RESP.
  - If tl_valid_i and expiry occur in the same cycle, tl_valid_i wins and there is no timeout pulse.
- RESP:
  - The owner's rsp_valid_o is high with rsp_allow_o. The other channel's rsp_valid_o stays 0.
  - On owner rsp_ready_i: rr_ptr becomes the non-owner, go to IDLE.
- tl_valid_i outside WAIT is ignored.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1; it never wraps in WAIT.
- Reset mid-operation: all state returns to IDLE, the pending request is dropped, and no response is issued.

## Timing
- Reset values:
  - All valid/ready/en outputs, rsp_allow_o and timeout_o are 0.
  - tl_addr_o, tl_num_bytes_o and tl_sid_o are 0; tl_access_type_o is ACCESS_NONE.
  - rr_ptr is 0.
- tl_* fields are stable from entry to ISSUE until the next IDLE handshake.
- Request handshake in cycle N: tl_transaction_en_o is high in N+1. If tl_ready_i is high in N+1, WAIT starts at N+2.
- tl_valid_i in cycle M: rsp_valid_o is high from M+1 and held, with rsp_allow_o constant, until rsp_ready_i.
- Response accepted in cycle R: IDLE at R+1, and a new request is accepted at the earliest in R+1.
- Throughput: at most one request in flight; there is no buffering beyond the single request register.
- Response outputs (rsp_valid_o, rsp_allow_o) are registered state. req_ready_o is combinational from state, rr_ptr and the valid inputs.

## Test plan
- Single read: addr 0x8000_0000, sid 3, num_bytes 8, tl_ready_i = 1, tl_valid_i with allow = 1 three cycles into WAIT -> tl_access_type_o = ACCESS_READ and tl_sid_o = 3 during ISSUE; rd_rsp_valid_o = 1, rd_rsp_allow_o = 1 one cycle later; wr_rsp_valid_o stays 0.
- Both channels valid after reset -> read is granted first, then write; with both held valid, grants alternate R, W, R, W over 4 requests.
- Execute fetch: rd_exec_i = 1 -> tl_access_type_o = ACCESS_EXECUTION; deny (tl_allow_i = 0) -> rd_rsp_allow_o = 0.
- Back-pressure: tl_ready_i low for 5 cycles in ISSUE -> tl_transaction_en_o held high with stable fields; rsp_ready_i low for 4 cycles -> rsp_valid_o and rsp_allow_o held and no new request accepted.
- Watchdog: TIMEOUT_CYCLES = 4 with no tl_valid_i -> timeout_o pulses on the 4th WAIT cycle and the response is a deny. tl_valid_i on that same cycle -> the decision is used and timeout_o stays 0.
- rst_ni asserted in WAIT -> all outputs return to reset values immediately; a late tl_valid_i is ignored; a subsequent write is granted first by rr_ptr only if read is idle.
